// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control unit: IF/ID/EX/MEM/WB sequencing with registered
// datapath controls, sticky illegal-instruction halt and retired-instruction count.
module multicycle_ctrl #(
   parameter int MEM_HANDSHAKE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        Zero,
   input  logic        dAck,
   output logic        PCSrc,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic        loadPC,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [3:0]  ALUCtrl,
   output logic        fetch,
   output logic        illegal,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   state_t      state, next_state;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        f7b5;
   logic        is_r, is_i, is_lw, is_sw, is_beq, legal;
   logic [3:0]  alu_dec;
   logic        src_dec;
   logic        zero_q;
   logic        mem_rd_d, mem_wr_d, reg_wr_d, mem2reg_d, load_pc_d, pc_src_d;
   logic        instr_unused;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign f7b5   = instr[30];
   assign instr_unused = ^{instr[31], instr[29:15], instr[11:7]};

   assign is_r   = (opcode == OP_R);
   assign is_i   = (opcode == OP_I);
   assign is_lw  = (opcode == OP_LOAD)  && (funct3 == 3'b010);
   assign is_sw  = (opcode == OP_STORE) && (funct3 == 3'b010);
   assign is_beq = (opcode == OP_BR)    && (funct3 == 3'b000);
   assign legal  = is_r | is_i | is_lw | is_sw | is_beq;
   assign src_dec = is_i | is_lw | is_sw;

   assign fetch = (state == S_IF);

   // funct7[5] only distinguishes SUB (R-type) and SRA/SRAI; I-type 000 is always ADD.
   always_comb begin
      alu_dec = ALU_ADD;
      if (is_beq) begin
         alu_dec = ALU_SUB;
      end else if (is_r || is_i) begin
         case (funct3)
            3'b000:  alu_dec = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010,
            3'b011:  alu_dec = ALU_SLT;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
         endcase
      end
   end

   always_comb begin
      // NOTE: every always_comb output is defaulted first so no latch can be inferred.
      next_state = state;
      case (state)
         S_IF:    next_state = S_ID;
         S_ID:    next_state = legal ? S_EX : S_HALT;
         S_EX:    next_state = (is_lw || is_sw) ? S_MEM : S_WB;
         S_MEM:   next_state = ((MEM_HANDSHAKE == 0) || dAck) ? S_WB : S_MEM;
         S_WB:    next_state = S_IF;
         S_HALT:  next_state = S_HALT;
         default: next_state = S_IF;
      endcase

      // Controls are registered against the state being entered, so they line up with it.
      mem_rd_d  = (next_state == S_MEM) && is_lw;
      mem_wr_d  = (next_state == S_MEM) && is_sw;
      load_pc_d = (next_state == S_WB);
      reg_wr_d  = load_pc_d && (is_r || is_i || is_lw);
      mem2reg_d = load_pc_d && is_lw;
      pc_src_d  = load_pc_d && is_beq && ((state == S_EX) ? Zero : zero_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst) state <= S_IF;
      else      state <= next_state;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         PCSrc    <= 1'b0;
         ALUSrc   <= 1'b0;
         RegWrite <= 1'b0;
         MemToReg <= 1'b0;
         loadPC   <= 1'b0;
         MemRead  <= 1'b0;
         MemWrite <= 1'b0;
         ALUCtrl  <= ALU_AND;
         illegal  <= 1'b0;
         instret  <= '0;
         zero_q   <= 1'b0;
      end else begin
         PCSrc    <= pc_src_d;
         RegWrite <= reg_wr_d;
         MemToReg <= mem2reg_d;
         loadPC   <= load_pc_d;
         MemRead  <= mem_rd_d;
         MemWrite <= mem_wr_d;
         if (next_state == S_HALT) begin
            ALUCtrl <= ALU_AND;
            ALUSrc  <= 1'b0;
            illegal <= 1'b1;
         end else if (state == S_ID) begin
            ALUCtrl <= alu_dec;
            ALUSrc  <= src_dec;
         end
         if (state == S_EX) zero_q  <= Zero;
         if (state == S_WB) instret <= instret + 32'd1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction behavioural model of the
// expected control trace, random legal instruction streams, plus directed scenarios.
module tb_multicycle_ctrl;

   localparam int B_PCSRC = 12, B_ALUSRC = 11, B_REGW = 10, B_M2R = 9, B_LPC = 8;
   localparam int B_MR = 7, B_MW = 6, B_FETCH = 1, B_ILL = 0;

   typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_BAD} kind_t;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic [31:0] instr;
   logic        Zero, dAck;

   logic        PCSrc_a, ALUSrc_a, RegWrite_a, MemToReg_a, loadPC_a, MemRead_a, MemWrite_a;
   logic        fetch_a, illegal_a;
   logic [3:0]  ALUCtrl_a;
   logic [31:0] instret_a;
   logic        PCSrc_b, ALUSrc_b, RegWrite_b, MemToReg_b, loadPC_b, MemRead_b, MemWrite_b;
   logic        fetch_b, illegal_b;
   logic [3:0]  ALUCtrl_b;
   logic [31:0] instret_b;
   logic [12:0] ctl_a, ctl_b;

   assign ctl_a = {PCSrc_a, ALUSrc_a, RegWrite_a, MemToReg_a, loadPC_a, MemRead_a,
                   MemWrite_a, ALUCtrl_a, fetch_a, illegal_a};
   assign ctl_b = {PCSrc_b, ALUSrc_b, RegWrite_b, MemToReg_b, loadPC_b, MemRead_b,
                   MemWrite_b, ALUCtrl_b, fetch_b, illegal_b};

   multicycle_ctrl #(.MEM_HANDSHAKE(1)) u_hs (
      .clk(clk), .rst(rst_a), .instr(instr), .Zero(Zero), .dAck(dAck),
      .PCSrc(PCSrc_a), .ALUSrc(ALUSrc_a), .RegWrite(RegWrite_a), .MemToReg(MemToReg_a),
      .loadPC(loadPC_a), .MemRead(MemRead_a), .MemWrite(MemWrite_a), .ALUCtrl(ALUCtrl_a),
      .fetch(fetch_a), .illegal(illegal_a), .instret(instret_a)
   );

   multicycle_ctrl #(.MEM_HANDSHAKE(0)) u_nh (
      .clk(clk), .rst(rst_b), .instr(instr), .Zero(Zero), .dAck(dAck),
      .PCSrc(PCSrc_b), .ALUSrc(ALUSrc_b), .RegWrite(RegWrite_b), .MemToReg(MemToReg_b),
      .loadPC(loadPC_b), .MemRead(MemRead_b), .MemWrite(MemWrite_b), .ALUCtrl(ALUCtrl_b),
      .fetch(fetch_b), .illegal(illegal_b), .instret(instret_b)
   );

   always #5 clk = ~clk;

   int          checks = 0, failures = 0;
   bit          sel = 1'b0;
   bit          hs = 1'b1;
   bit          fresh = 1'b0;
   logic [12:0] exp_ctl;
   logic [31:0] exp_ir;
   logic [31:0] ir_model = '0;
   logic [3:0]  alu_h = '0;
   logic        src_h = 1'b0;
   int          cyc = 0, mr_cnt = 0, mw_cnt = 0, rw_cnt = 0, lp_cnt = 0, wb_idx = 0;
   logic [12:0] wb_ctl = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [12:0] mk(input logic pcsrc, input logic alusrc, input logic regw,
                                      input logic m2r, input logic lpc, input logic mr,
                                      input logic mw, input logic [3:0] alu,
                                      input logic fch, input logic ill);
      return {pcsrc, alusrc, regw, m2r, lpc, mr, mw, alu, fch, ill};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic kind_t kind_of(input logic [31:0] i);
      case (i[6:0])
         7'b0110011: return K_R;
         7'b0010011: return K_I;
         7'b0000011: return (i[14:12] == 3'b010) ? K_LW : K_BAD;
         7'b0100011: return (i[14:12] == 3'b010) ? K_SW : K_BAD;
         7'b1100011: return (i[14:12] == 3'b000) ? K_BEQ : K_BAD;
         default:    return K_BAD;
      endcase
   endfunction

   // ALU operation table: loads/stores add, BEQ subtracts, ALU ops follow funct3.
   function automatic logic [3:0] alu_of(input logic [31:0] i, input kind_t k);
      if (k == K_LW || k == K_SW) return 4'b0010;
      if (k == K_BEQ) return 4'b0110;
      case (i[14:12])
         3'd0:    return (k == K_R && i[30]) ? 4'b0110 : 4'b0010;
         3'd1:    return 4'b1001;
         3'd2,
         3'd3:    return 4'b0111;
         3'd4:    return 4'b1101;
         3'd5:    return i[30] ? 4'b1010 : 4'b1000;
         3'd6:    return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] i;
      i = $urandom;
      case ($urandom_range(0, 4))
         0: i[6:0] = 7'b0110011;
         1: i[6:0] = 7'b0010011;
         2: begin i[6:0] = 7'b0000011; i[14:12] = 3'b010; end
         3: begin i[6:0] = 7'b0100011; i[14:12] = 3'b010; end
         default: begin i[6:0] = 7'b1100011; i[14:12] = 3'b000; end
      endcase
      return i;
   endfunction

   // One clock cycle: publish the expected outputs for it, drive inputs, move on.
   task automatic step(input logic [12:0] c, input logic z, input logic ack);
      exp_ctl = c;
      exp_ir  = ir_model;
      fresh   = 1'b1;
      Zero    = z;
      dAck    = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic z, input int delay);
      kind_t      k;
      logic [3:0] alu;
      logic       src;
      int         n;
      k   = kind_of(ins);
      alu = alu_of(ins, k);
      src = (k == K_I || k == K_LW || k == K_SW);
      instr = ins;
      step(mk(0, src_h, 0, 0, 0, 0, 0, alu_h, 1, 0), rb(), rb());
      step(mk(0, src_h, 0, 0, 0, 0, 0, alu_h, 0, 0), rb(), rb());
      if (k == K_BAD) begin
         alu_h = '0;
         src_h = 1'b0;
         for (int c = 0; c < 20; c++) step(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1), rb(), rb());
         return;
      end
      alu_h = alu;
      src_h = src;
      step(mk(0, src, 0, 0, 0, 0, 0, alu, 0, 0), z, rb());
      if (k == K_LW || k == K_SW) begin
         n = hs ? delay + 1 : 1;
         for (int m = 0; m < n; m++)
            step(mk(0, src, 0, 0, 0, k == K_LW, k == K_SW, alu, 0, 0), rb(),
                 hs ? logic'(m == n - 1) : rb());
      end
      step(mk(k == K_BEQ && z, src, k == K_R || k == K_I || k == K_LW, k == K_LW, 1, 0, 0,
              alu, 0, 0), rb(), rb());
      ir_model = ir_model + 32'd1;
   endtask

   task automatic clear_counts();
      mr_cnt = 0; mw_cnt = 0; rw_cnt = 0; lp_cnt = 0; wb_idx = 0; wb_ctl = '0;
   endtask

   task automatic model_reset();
      ir_model = '0; alu_h = '0; src_h = 1'b0;
   endtask

   // Compare process plus event counters for the directed scenarios.
   always @(negedge clk) begin
      logic [12:0] act_ctl;
      logic [31:0] act_ir;
      act_ctl = sel ? ctl_b : ctl_a;
      act_ir  = sel ? instret_b : instret_a;
      if (fresh) begin
         check("cycle", {19'b0, act_ctl, act_ir}, {19'b0, exp_ctl, exp_ir});
         fresh = 1'b0;
      end
      if (act_ctl[B_FETCH]) cyc = 0;
      else                  cyc++;
      if (act_ctl[B_MR])   mr_cnt++;
      if (act_ctl[B_MW])   mw_cnt++;
      if (act_ctl[B_REGW]) rw_cnt++;
      if (act_ctl[B_LPC]) begin
         lp_cnt++;
         wb_ctl = act_ctl;
         wb_idx = cyc;
      end
   end

   initial begin
      instr = 32'h0000_0013; Zero = 1'b0; dAck = 1'b0;
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctl_a", ctl_a, mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0));
      check("reset_instret_a", instret_a, 0);
      check("reset_ctl_b", ctl_b, mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0));
      rst_a = 1'b1;

      // LW aborted by reset in MEM: MemRead drops at once, nothing retires.
      clear_counts();
      instr = 32'h0040_A183;
      step(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0), 0, 1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0), 0, 0);
      step(mk(0, 1, 0, 0, 0, 0, 0, 4'b0010, 0, 0), 0, 1);
      exp_ctl = mk(0, 1, 0, 0, 0, 1, 0, 4'b0010, 0, 0);
      exp_ir = '0; fresh = 1'b1; dAck = 1'b0;
      @(negedge clk);
      #1;
      rst_a = 1'b0;
      #1;
      check("abort_memread", MemRead_a, 0);
      check("abort_alu", ALUCtrl_a, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_a = 1'b1;
      model_reset();
      check("abort_instret", instret_a, 0);
      check("abort_loadpc", lp_cnt, 0);
      check("abort_regwrite", rw_cnt, 0);

      // add x3,x1,x2
      clear_counts();
      run_instr(32'h0020_81B3, rb(), 0);
      check("add_wb_index", wb_idx, 3);
      check("add_aluctrl", wb_ctl[5:2], 4'b0010);
      check("add_alusrc", wb_ctl[B_ALUSRC], 0);
      check("add_regwrite", wb_ctl[B_REGW], 1);
      check("add_pcsrc", wb_ctl[B_PCSRC], 0);
      check("add_instret", instret_a, 1);

      // LW with acknowledge three cycles into MEM
      clear_counts();
      run_instr(32'h0040_A183, 0, 3);
      check("lw_memread_cycles", mr_cnt, 4);
      check("lw_wb_index", wb_idx, 7);
      check("lw_memtoreg", wb_ctl[B_M2R], 1);
      check("lw_regwrite", wb_ctl[B_REGW], 1);

      clear_counts();
      run_instr(32'h0020_8463, 1, 0);
      check("beq_taken_pcsrc", wb_ctl[B_PCSRC], 1);
      check("beq_taken_loadpc", lp_cnt, 1);
      check("beq_regwrite", rw_cnt, 0);
      run_instr(32'h0020_8463, 0, 0);
      check("beq_not_taken_pcsrc", wb_ctl[B_PCSRC], 0);

      for (int n = 0; n < 60; n++) run_instr(rand_instr(), rb(), $urandom_range(0, 4));

      // Switch to the no-handshake instance.
      rst_a = 1'b0;
      sel = 1'b1;
      hs = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      rst_b = 1'b1;
      clear_counts();
      run_instr(32'h0020_A423, rb(), 5);
      check("sw_memwrite_cycles", mw_cnt, 1);
      check("sw_regwrite", rw_cnt, 0);
      check("sw_loadpc", lp_cnt, 1);

      for (int n = 0; n < 30; n++) run_instr(rand_instr(), rb(), 0);

      run_instr(32'h0000_007F, rb(), 0);
      check("halt_illegal", illegal_b, 1);
      check("halt_ctl", ctl_b, mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1));
      check("halt_instret", instret_b, 31);
      rst_b = 1'b0;
      #1;
      check("halt_rst_illegal", illegal_b, 0);
      check("halt_rst_fetch", fetch_b, 1);
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      model_reset();
      run_instr(32'h0020_81B3, rb(), 0);
      check("restart_instret", instret_b, 1);

      // Branch opcode with funct3 001 is outside the decoded set and halts.
      run_instr(32'h0020_9463, rb(), 0);
      check("bne_illegal", illegal_b, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
